// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches words over imem req/ack and hands them to the decoder via valid/ready.
// Define INSTR_FETCH_PREFETCH_EN to add a one-entry prefetch buffer for back-to-back issue.
module instr_fetch #(
  parameter int PC_W  = 4,
  parameter int OP_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [OP_W-1:0]  imem_rdata,
  output logic [OP_W-1:0]  op,
  output logic             op_valid,
  input  logic             op_ready,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             pc_we,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t           state, state_nx;
  logic [PC_W-1:0]  pc_nx, addr_nx, pc_inc, next_pc;
  logic [OP_W-1:0]  op_nx;
  logic             op_valid_nx, req_nx, consume;
  logic [CNT_W-1:0] cnt_nx;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic [OP_W-1:0]  pf_data, pf_data_nx;
  logic [PC_W-1:0]  pf_pc, pf_pc_nx;
  logic             pf_valid, pf_valid_nx, squash, squash_nx;
`endif

  assign consume = op_valid & op_ready;
  assign pc_inc  = pc + 1'b1;
  assign next_pc = pc_we ? pc_in : pc_inc;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_nx    = state;
    pc_nx       = pc;
    op_nx       = op;
    op_valid_nx = op_valid;
    req_nx      = imem_req;
    addr_nx     = imem_addr;
    cnt_nx      = instr_count;
`ifdef INSTR_FETCH_PREFETCH_EN
    pf_data_nx  = pf_data;
    pf_pc_nx    = pf_pc;
    pf_valid_nx = pf_valid;
    squash_nx   = squash;
`endif

    if (consume && instr_count != '1) cnt_nx = instr_count + 1'b1;

    case (state)
      IDLE: begin
        if (run) begin
          state_nx = FETCH;
          req_nx   = 1'b1;
          addr_nx  = pc;
        end
      end

      FETCH: begin
        if (imem_ack) begin
`ifdef INSTR_FETCH_PREFETCH_EN
          if (squash) begin
            // Stale prefetch finally returned; now the jump target may be requested.
            squash_nx = 1'b0;
            req_nx    = run;
            addr_nx   = pc;
            state_nx  = run ? FETCH : IDLE;
          end else begin
            op_nx       = imem_rdata;
            op_valid_nx = 1'b1;
            req_nx      = run;
            addr_nx     = pc_inc;
            state_nx    = HOLD;
          end
`else
          op_nx       = imem_rdata;
          op_valid_nx = 1'b1;
          req_nx      = 1'b0;
          state_nx    = HOLD;
`endif
        end
      end

      HOLD: begin
`ifdef INSTR_FETCH_PREFETCH_EN
        if (consume) begin
          pf_valid_nx = 1'b0;
          if (pc_we) begin
            op_valid_nx = 1'b0;
            pc_nx       = pc_in;
            if (imem_req && !imem_ack) begin
              squash_nx = 1'b1;
              state_nx  = FETCH;
            end else begin
              req_nx   = run;
              addr_nx  = pc_in;
              state_nx = run ? FETCH : IDLE;
            end
          end else if (pf_valid) begin
            op_nx   = pf_data;
            pc_nx   = pf_pc;
            req_nx  = run;
            addr_nx = pf_pc + 1'b1;
          end else if (imem_req && imem_ack) begin
            // Prefetch lands on the consume cycle: bypass it straight into op.
            op_nx   = imem_rdata;
            pc_nx   = imem_addr;
            req_nx  = run;
            addr_nx = imem_addr + 1'b1;
          end else if (imem_req) begin
            op_valid_nx = 1'b0;
            pc_nx       = imem_addr;
            state_nx    = FETCH;
          end else begin
            op_valid_nx = 1'b0;
            pc_nx       = pc_inc;
            req_nx      = run;
            addr_nx     = pc_inc;
            state_nx    = run ? FETCH : IDLE;
          end
        end else if (imem_req && imem_ack) begin
          pf_data_nx  = imem_rdata;
          pf_pc_nx    = imem_addr;
          pf_valid_nx = 1'b1;
          req_nx      = 1'b0;
        end else if (!imem_req && !pf_valid && run) begin
          req_nx  = 1'b1;
          addr_nx = pc_inc;
        end
`else
        if (consume) begin
          op_valid_nx = 1'b0;
          pc_nx       = next_pc;
          req_nx      = run;
          addr_nx     = next_pc;
          state_nx    = run ? FETCH : IDLE;
        end
`endif
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      op          <= '0;
      op_valid    <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_count <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      op          <= op_nx;
      op_valid    <= op_valid_nx;
      imem_req    <= req_nx;
      imem_addr   <= addr_nx;
      instr_count <= cnt_nx;
    end
  end

`ifdef INSTR_FETCH_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pf_data  <= '0;
      pf_pc    <= '0;
      pf_valid <= 1'b0;
      squash   <= 1'b0;
    end else begin
      pf_data  <= pf_data_nx;
      pf_pc    <= pf_pc_nx;
      pf_valid <= pf_valid_nx;
      squash   <= squash_nx;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch (default build): table of consume vectors plus
// hand sequences for reset mid-fetch, run deassertion and counter saturation.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, run, op_ready, pc_we;
  logic [3:0]  pc_in;
  logic        imem_req, imem_ack, op_valid;
  logic [3:0]  imem_addr, pc;
  logic [31:0] imem_rdata, op;
  logic [15:0] instr_count;

  logic        req2, opv2;
  logic [3:0]  addr2, pc2;
  logic [31:0] op2;
  logic [2:0]  instr_count2;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .op(op), .op_valid(op_valid), .op_ready(op_ready),
    .pc_in(pc_in), .pc_we(pc_we), .pc(pc), .instr_count(instr_count)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  instr_fetch #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .op(op2), .op_valid(opv2), .op_ready(op_ready),
    .pc_in(pc_in), .pc_we(pc_we), .pc(pc2), .instr_count(instr_count2)
  );

  // Memory model: word = {28'h0, addr}, ack after mem_delay request cycles.
  int   mem_delay = 0;
  int   req_age;
  logic force_ack = 1'b0;

  assign imem_ack   = force_ack | (imem_req && (req_age == mem_delay));
  assign imem_rdata = force_ack ? 32'hDEAD_BEEF : {28'h0, imem_addr};

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) req_age <= 0;
    else                              req_age <= req_age + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  addr_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_op();
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_underflow: consume of op %0h with nothing expected", op);
    end else begin
      e = exp_q.pop_front();
      check("op", op, e);
      check("pc", {28'h0, pc}, {28'h0, e[3:0]});
    end
  endtask

  task automatic wait_valid(input string name);
    int cyc = 0;
    while (!op_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, {31'h0, op_valid}, 32'h1);
  endtask

  task automatic consume_n(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    op_ready = 1'b1;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      if (op_valid) begin
        got++;
        check_op();
      end
      @(posedge clk); #1;
      cyc++;
    end
    op_ready = 1'b0;
    check("consume_budget", got, n);
  endtask

  // Request address must stay put until the ack cycle.
  logic       prev_pending = 1'b0;
  logic [3:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!rst && imem_req && prev_pending) check("addr_stable", {28'h0, imem_addr}, {28'h0, prev_addr});
    if (!rst && imem_req && imem_ack) addr_log.push_back(imem_addr);
    prev_pending <= imem_req && !imem_ack && !rst;
    prev_addr    <= imem_addr;
  end

  typedef struct {
    logic        we;
    logic [3:0]  tgt;
    int          dly;    // memory latency of the fetch this consume starts
    int          stall;  // cycles of op_ready=0 (with a stray pc_we) before consuming
    logic [31:0] exp_op;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0, 4'd0,  3, 0, 32'd0};
    tbl[1] = '{1'b0, 4'd0,  0, 5, 32'd1};
    tbl[2] = '{1'b1, 4'd9,  0, 0, 32'd2};
    tbl[3] = '{1'b0, 4'd0,  1, 3, 32'd9};
    tbl[4] = '{1'b1, 4'd15, 2, 0, 32'd10};
    tbl[5] = '{1'b0, 4'd0,  0, 1, 32'd15};
    tbl[6] = '{1'b1, 4'd14, 0, 0, 32'd0};
    tbl[7] = '{1'b1, 4'd4,  3, 2, 32'd14};
    tbl[8] = '{1'b0, 4'd0,  3, 0, 32'd4};

    rst = 1'b1; run = 1'b0; op_ready = 1'b0; pc_we = 1'b0; pc_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc",       {28'h0, pc},        32'h0);
    check("rst_op",       op,                 32'h0);
    check("rst_op_valid", {31'h0, op_valid},  32'h0);
    check("rst_req",      {31'h0, imem_req},  32'h0);
    check("rst_addr",     {28'h0, imem_addr}, 32'h0);
    check("rst_count",    {16'h0, instr_count}, 32'h0);

    // Zero-wait streaming through the PC wrap.
    rst = 1'b0; run = 1'b1;
    for (int i = 0; i < 17; i++) exp_q.push_back(32'(i % 16));
    consume_n(17, 400);
    check("count17",   {16'h0, instr_count},  32'd17);
    check("count_sat", {29'h0, instr_count2}, 32'd7);
    check("addr_log_len", {31'h0, addr_log.size() >= 17}, 32'h1);
    for (int i = 0; i < 17 && i < addr_log.size(); i++)
      check("addr_wrap", {28'h0, addr_log[i]}, 32'(i % 16));
    addr_log.delete();

    // Reset mid-FETCH with an ack in the reset cycle.
    wait_valid("pre_rst_valid");
    mem_delay = 10;
    exp_q.push_back(32'd1);
    consume_n(1, 4);
    repeat (2) @(posedge clk);
    #1;
    check("mid_fetch_req", {31'h0, imem_req}, 32'h1);
    rst = 1'b1; force_ack = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; force_ack = 1'b0; mem_delay = 0;
    check("rst2_op_valid", {31'h0, op_valid}, 32'h0);
    check("rst2_pc",       {28'h0, pc},       32'h0);
    check("rst2_op",       op,                32'h0);
    check("rst2_count",    {16'h0, instr_count}, 32'h0);

    // Table: stalls, delayed acks, jumps and ignored pc_we pulses.
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(tbl[i].exp_op);
      wait_valid("tbl_valid");
      pc_we = (tbl[i].stall > 0);
      pc_in = 4'd7;
      for (int s = 0; s < tbl[i].stall; s++) begin
        @(negedge clk);
        check("stall_op",    op,                tbl[i].exp_op);
        check("stall_valid", {31'h0, op_valid}, 32'h1);
        check("stall_req",   {31'h0, imem_req}, 32'h0);
        @(posedge clk); #1;
      end
      pc_we = tbl[i].we; pc_in = tbl[i].tgt; mem_delay = tbl[i].dly; op_ready = 1'b1;
      @(negedge clk);
      check_op();
      @(posedge clk); #1;
      op_ready = 1'b0; pc_we = 1'b0;
    end

    // run dropped while the fetch of pc=5 is outstanding.
    run = 1'b0;
    check("drop_req",  {31'h0, imem_req},  32'h1);
    check("drop_addr", {28'h0, imem_addr}, 32'd5);
    exp_q.push_back(32'd5);
    wait_valid("drop_valid");
    consume_n(1, 4);
    repeat (4) begin
      @(negedge clk);
      check("park_req",   {31'h0, imem_req}, 32'h0);
      check("park_pc",    {28'h0, pc},       32'd6);
      check("park_valid", {31'h0, op_valid}, 32'h0);
    end
    @(posedge clk); #1;
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    check("stray_ack_valid", {31'h0, op_valid}, 32'h0);
    check("stray_ack_op",    op,                32'd5);
    check("count10",         {16'h0, instr_count}, 32'd10);
    check("count_sat2",      {29'h0, instr_count2}, 32'd7);

    run = 1'b1;
    for (int c = 0; c < 8 && !imem_req; c++) begin
      @(posedge clk); #1;
    end
    check("resume_req",  {31'h0, imem_req},  32'h1);
    check("resume_addr", {28'h0, imem_addr}, 32'd6);
    exp_q.push_back(32'd6);
    wait_valid("resume_valid");
    consume_n(1, 4);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
